acs_array: RTL and testbench

ACS_ARRAY -- requirements
Module: acs_array

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/acs_array_if.sv | 30 +++
 rtl/acs_bfly.sv | 37 +++
 rtl/acs_array.sv | 120 ++++++++++++
 tb/tb_acs_array.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants and helpers: symbol width, start metric, parity and 2-bit distance.
package viterbi_pkg;

    localparam int unsigned SYM_W = 2;

    // Metric given to every non-zero state on start; leaves headroom above it.
    function automatic int unsigned init_metric(input int unsigned bm_w);
        return 32'd1 << (bm_w - 2);
    endfunction

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

    function automatic logic [1:0] hamming2(input logic [SYM_W-1:0] a,
                                            input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/acs_array_if.sv
// Symbol-in / metrics-out handshake bundle for the ACS array.
interface acs_array_if
    import viterbi_pkg::*;
#(
    parameter int unsigned K    = 3,
    parameter int unsigned BM_W = 7
);
    localparam int unsigned NS = 1 << (K - 1);

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [SYM_W-1:0]     data_recv;
    logic                 out_valid;
    logic                 out_ready;
    logic [NS-1:0]        decisions;
    logic [NS*BM_W-1:0]   pm_out;
    logic [K-2:0]         best_state;

    modport master (
        output start, in_valid, data_recv, out_ready,
        input  in_ready, out_valid, decisions, pm_out, best_state
    );

    modport slave (
        input  start, in_valid, data_recv, out_ready,
        output in_ready, out_valid, decisions, pm_out, best_state
    );

endinterface

// File: rtl/acs_bfly.sv
// Add-compare-select for one trellis state: two branch distances, two sums, select, decision.
module acs_bfly
    import viterbi_pkg::*;
#(
    parameter int unsigned K     = 3,
    parameter int unsigned BM_W  = 7,
    parameter int unsigned G0    = 'o7,
    parameter int unsigned G1    = 'o5,
    parameter int unsigned State = 0
) (
    input  logic [BM_W-1:0]  pm0,
    input  logic [BM_W-1:0]  pm1,
    input  logic [SYM_W-1:0] sym,
    output logic [BM_W:0]    metric,
    output logic             dec
);
    localparam int unsigned NS    = 1 << (K - 1);
    localparam int unsigned InBit = (State >> (K - 2)) & 1;
    localparam int unsigned P0    = (State << 1) & (NS - 1);
    localparam int unsigned Reg0  = (InBit << (K - 1)) | P0;
    localparam int unsigned Reg1  = Reg0 | 1;

    localparam logic [SYM_W-1:0] Lab0 = {parity(G0 & Reg0), parity(G1 & Reg0)};
    localparam logic [SYM_W-1:0] Lab1 = {parity(G0 & Reg1), parity(G1 & Reg1)};

    logic [BM_W:0] sum0;
    logic [BM_W:0] sum1;

    always_comb begin
        sum0   = {1'b0, pm0} + (BM_W+1)'(hamming2(sym, Lab0));
        sum1   = {1'b0, pm1} + (BM_W+1)'(hamming2(sym, Lab1));
        // Strictly-smaller test so a tie keeps the even predecessor.
        dec    = sum1 < sum0;
        metric = dec ? sum1 : sum0;
    end

endmodule

// File: rtl/acs_array.sv
// Full-trellis ACS stage: one butterfly per state, metric registers, argmin, valid/ready.
// Define ACS_NORM_EN to rescale metrics instead of relying on saturation.
module acs_array
    import viterbi_pkg::*;
#(
    parameter int unsigned K    = 3,
    parameter int unsigned BM_W = 7,
    parameter int unsigned G0   = 'o7,
    parameter int unsigned G1   = 'o5
) (
    input  logic        clk,
    input  logic        rst,
    acs_array_if.slave  bus
);
    localparam int unsigned NS = 1 << (K - 1);
    localparam int unsigned SW = K - 1;

    localparam logic [BM_W-1:0] Init  = BM_W'(init_metric(BM_W));
    localparam logic [BM_W-1:0] PmMax = '1;
    localparam logic [BM_W:0]   Half  = (BM_W+1)'(1) << (BM_W - 1);

    logic [BM_W-1:0] pm_q   [NS];
    logic [BM_W-1:0] pm_src [NS];
    logic [BM_W-1:0] new_pm [NS];
    logic [BM_W:0]   raw    [NS];
    logic [BM_W:0]   adj    [NS];
    logic [NS-1:0]   dec_d;
    logic [NS-1:0]   decisions_q;
    logic [SW-1:0]   best_d;
    logic [SW-1:0]   best_q;
    logic [BM_W-1:0] best_val;
    logic            out_valid_q;
    logic            accept;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A start coinciding with a symbol runs the ACS from the start metrics.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            if (bus.start) pm_src[s] = (s == 0) ? '0 : Init;
            else           pm_src[s] = pm_q[s];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_bfly
        localparam int unsigned P0 = (s << 1) & (NS - 1);
        acs_bfly #(
            .K     (K),
            .BM_W  (BM_W),
            .G0    (G0),
            .G1    (G1),
            .State (s)
        ) u_bfly (
            .pm0    (pm_src[P0]),
            .pm1    (pm_src[P0 + 1]),
            .sym    (bus.data_recv),
            .metric (raw[s]),
            .dec    (dec_d[s])
        );
    end

`ifdef ACS_NORM_EN
    logic all_high;
`endif

    always_comb begin
`ifdef ACS_NORM_EN
        all_high = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (raw[s] < Half) all_high = 1'b0;
        end
`endif
        for (int s = 0; s < NS; s++) begin
            adj[s] = raw[s];
`ifdef ACS_NORM_EN
            if (all_high) adj[s] = raw[s] - Half;
`endif
            new_pm[s] = (adj[s] > {1'b0, PmMax}) ? PmMax : adj[s][BM_W-1:0];
        end
        best_d   = '0;
        best_val = new_pm[0];
        for (int s = 1; s < NS; s++) begin
            if (new_pm[s] < best_val) begin
                best_val = new_pm[s];
                best_d   = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : Init;
            decisions_q <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= new_pm[s];
            decisions_q <= dec_d;
            best_q      <= best_d;
            out_valid_q <= 1'b1;
        end else if (bus.start) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : Init;
            decisions_q <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_pack
        assign bus.pm_out[s*BM_W +: BM_W] = pm_q[s];
    end

    assign bus.decisions  = decisions_q;
    assign bus.best_state = best_q;
    assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_acs_array.sv
// Scoreboard bench for acs_array (K=3, 7/5): a forward trellis model predicts every result.
module tb_acs_array;
    localparam int unsigned K    = 3;
    localparam int unsigned BM_W = 7;
    localparam int unsigned NS   = 1 << (K - 1);
    localparam int unsigned G0   = 'o7;
    localparam int unsigned G1   = 'o5;
    localparam int          INIT = 32;
    localparam int          PMAX = 127;

    typedef struct packed {
        logic [NS*BM_W-1:0] pm;
        logic [NS-1:0]      dec;
        logic [K-2:0]       best;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    int   mpm[NS];
    exp_t mon_e;
    exp_t mon_got;

    always #5 clk = ~clk;

    acs_array_if #(.K(K), .BM_W(BM_W)) bus ();

    acs_array #(
        .K    (K),
        .BM_W (BM_W),
        .G0   (G0),
        .G1   (G1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic model_init();
        for (int s = 0; s < NS; s++) mpm[s] = (s == 0) ? 0 : INIT;
    endtask

    // Forward formulation: every (state, input) pair drives its successor.
    task automatic model_step(input logic [1:0] sym, output exp_t e);
        int cand[NS][2];
        int nm[NS];
        logic [K-1:0] rv;
        logic [K-1:0] g0v;
        logic [K-1:0] g1v;
        int bm, nxt, bi;
        logic c1, c0;
        g0v = G0[K-1:0];
        g1v = G1[K-1:0];
        for (int p = 0; p < NS; p++) begin
            for (int b = 0; b < 2; b++) begin
                rv  = K'((b << (K - 1)) | p);
                c1  = ^(g0v & rv);
                c0  = ^(g1v & rv);
                bm  = int'(c1 != sym[1]) + int'(c0 != sym[0]);
                nxt = (b << (K - 2)) | (p >> 1);
                cand[nxt][p & 1] = mpm[p] + bm;
            end
        end
        for (int n = 0; n < NS; n++) begin
            e.dec[n] = cand[n][1] < cand[n][0];
            nm[n]    = e.dec[n] ? cand[n][1] : cand[n][0];
        end
`ifdef ACS_NORM_EN
        begin
            bit hi;
            hi = 1'b1;
            for (int n = 0; n < NS; n++) if (nm[n] < 64) hi = 1'b0;
            if (hi) for (int n = 0; n < NS; n++) nm[n] = nm[n] - 64;
        end
`endif
        bi = 0;
        for (int n = 0; n < NS; n++) begin
            if (nm[n] > PMAX) nm[n] = PMAX;
            mpm[n] = nm[n];
            e.pm[n*BM_W +: BM_W] = BM_W'(nm[n]);
            if (nm[n] < nm[bi]) bi = n;
        end
        e.best = (K-1)'(bi);
    endtask

    // Scoreboard: pop on every consumed result, push on every accepted symbol.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            model_init();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                mon_got = {bus.pm_out, bus.decisions, bus.best_state};
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected got=%h required=<no pending result>", mon_got);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_got !== mon_e) begin
                        n_err++;
                        $display("FAIL sb_result got pm=%h dec=%b best=%0d required pm=%h dec=%b best=%0d",
                                 bus.pm_out, bus.decisions, bus.best_state,
                                 mon_e.pm, mon_e.dec, mon_e.best);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bus.start) model_init();
                model_step(bus.data_recv, mon_e);
                q.push_back(mon_e);
            end else if (bus.start) begin
                model_init();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [1:0] sym, input logic ordy);
        bus.start     = st;
        bus.in_valid  = v;
        bus.data_recv = sym;
        bus.out_ready = ordy;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d required=0", name, q.size());
        end
    endtask

    task automatic test_reset();
        logic [NS*BM_W-1:0] init_vec;
        init_vec = {7'd32, 7'd32, 7'd32, 7'd0};
        drive(0, 0, 2'b00, 1);
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_handshake got ov/ir=%b required=01", {bus.out_valid, bus.in_ready});
        end
        n_cmp++;
        if (bus.pm_out !== init_vec) begin
            n_err++;
            $display("FAIL reset_pm got=%h required=%h", bus.pm_out, init_vec);
        end
        n_cmp++;
        if ({bus.decisions, bus.best_state} !== '0) begin
            n_err++;
            $display("FAIL reset_dec_best got dec=%b best=%0d required 0/0",
                     bus.decisions, bus.best_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_zero();
        logic [NS*BM_W-1:0] req;
        req = {7'd33, 7'd2, 7'd33, 7'd0};
        drive(1, 0, 2'b00, 1);
        tick();
        drive(0, 1, 2'b00, 1);
        tick();
        drive(0, 0, 2'b00, 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.pm_out !== req) begin
            n_err++;
            $display("FAIL start_zero got ov=%b pm=%h required ov=1 pm=%h", bus.out_valid, bus.pm_out, req);
        end
        n_cmp++;
        if ({bus.decisions, bus.best_state} !== '0) begin
            n_err++;
            $display("FAIL start_zero_dec got dec=%b best=%0d required 0/0", bus.decisions, bus.best_state);
        end
        wait_drain("start_zero");
    endtask

    task automatic test_start_sym();
        logic [NS*BM_W-1:0] req;
        req = {7'd33, 7'd0, 7'd33, 7'd2};
        drive(1, 1, 2'b11, 1);
        tick();
        drive(0, 0, 2'b00, 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.pm_out !== req) begin
            n_err++;
            $display("FAIL start_sym got ov=%b pm=%h required ov=1 pm=%h", bus.out_valid, bus.pm_out, req);
        end
        wait_drain("start_sym");
    endtask

    task automatic test_noiseless();
        logic [K-2:0] enc;
        logic [K-1:0] rv;
        logic [3:0]   pat;
        logic         b;
        logic [1:0]   sym;
        pat = 4'b1101;  // bit i gives 1,0,1,1,...
        enc = '0;
        drive(1, 0, 2'b00, 1);
        tick();
        for (int i = 0; i < 32; i++) begin
            b   = pat[i % 4];
            rv  = {b, enc};
            sym = {^(rv & G0[K-1:0]), ^(rv & G1[K-1:0])};
            enc = {b, enc[K-2:1]};
            drive(0, 1, sym, 1);
            tick();
            n_cmp++;
            if (bus.best_state !== enc) begin
                n_err++;
                $display("FAIL noiseless_best step=%0d got=%0d required=%0d", i, bus.best_state, enc);
            end
            n_cmp++;
            if (bus.pm_out[enc*BM_W +: BM_W] !== '0) begin
                n_err++;
                $display("FAIL noiseless_pm step=%0d got=%0d required=0", i, bus.pm_out[enc*BM_W +: BM_W]);
            end
        end
        drive(0, 0, 2'b00, 1);
        wait_drain("noiseless");
    endtask

    task automatic test_back_to_back();
        exp_t head;
        drive(0, 1, 2'b01, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'b10, 0);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_handshake cyc=%0d got ir=%b ov=%b required ir=0 ov=1",
                         i, bus.in_ready, bus.out_valid);
            end
            head = (q.size() != 0) ? q[0] : '0;
            n_cmp++;
            if ({bus.pm_out, bus.decisions, bus.best_state} !== head || q.size() != 1) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d got pm=%h pending=%0d required pm=%h pending=1",
                         i, bus.pm_out, q.size(), head.pm);
            end
            tick();
        end
        drive(0, 1, 2'b10, 1);
        tick();
        drive(0, 0, 2'b00, 1);
        wait_drain("stall");
    endtask

    task automatic test_saturation();
        drive(1, 0, 2'b00, 1);
        tick();
        for (int i = 0; i < 400; i++) begin
            drive(0, 1, 2'b11, 1);
            tick();
        end
        drive(0, 0, 2'b00, 1);
`ifdef ACS_NORM_EN
        for (int s = 0; s < NS; s++) begin
            n_cmp++;
            if (bus.pm_out[s*BM_W +: BM_W] >= 7'd127) begin
                n_err++;
                $display("FAIL norm_bound state=%0d got=%0d required<127", s, bus.pm_out[s*BM_W +: BM_W]);
            end
        end
`else
        n_cmp++;
        if (bus.pm_out !== {NS*BM_W{1'b1}}) begin
            n_err++;
            $display("FAIL sat_all got=%h required=%h", bus.pm_out, {NS*BM_W{1'b1}});
        end
`endif
        wait_drain("saturation");
    endtask

    task automatic test_rst_midflight();
        logic [NS*BM_W-1:0] init_vec;
        init_vec = {7'd32, 7'd32, 7'd32, 7'd0};
        drive(0, 1, 2'b11, 1);
        tick();
        drive(0, 0, 2'b00, 0);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_valid got=%b required=1", bus.out_valid);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.pm_out !== init_vec) begin
            n_err++;
            $display("FAIL rst_mid got ov=%b pm=%h required ov=0 pm=%h", bus.out_valid, bus.pm_out, init_vec);
        end
        rst = 1'b0;
        drive(0, 0, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_result cyc=%0d got ov=%b required=0", i, bus.out_valid);
            end
        end
    endtask

    initial begin
        drive(0, 0, 2'b00, 1);
        test_reset();
        test_start_zero();
        test_start_sym();
        test_noiseless();
        test_back_to_back();
        test_saturation();
        test_rst_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
